// File: rtl/ring_link_arbiter.sv
// Ring output link arbiter: pass-through vs. local injection with bounded local
// starvation, feeding a small output FIFO so the link is driven from flops.
module ring_link_arbiter #(
  parameter int unsigned DataWidth     = 64,
  parameter int unsigned FifoDepth     = 2,
  parameter int unsigned MaxPassStreak = 4,
  localparam int unsigned CntWidth     = $clog2(FifoDepth + 1),
  localparam int unsigned StreakWidth  = $clog2(MaxPassStreak + 1)
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [DataWidth-1:0] pass_data_i,
  input  logic                 pass_valid_i,
  output logic                 pass_ready_o,
  input  logic [DataWidth-1:0] local_data_i,
  input  logic                 local_valid_i,
  output logic                 local_ready_o,
  output logic [DataWidth-1:0] ring_data_o,
  output logic                 ring_valid_o,
  input  logic                 ring_ready_i,
  output logic [CntWidth-1:0]  occupancy_o,
  output logic                 local_src_o
);

  localparam int unsigned PtrWidth = (FifoDepth > 1) ? $clog2(FifoDepth) : 1;

  typedef struct packed {
    logic                 src;
    logic [DataWidth-1:0] data;
  } entry_t;

  entry_t                 mem_q [FifoDepth];
  logic [PtrWidth-1:0]    head_q;
  logic [PtrWidth-1:0]    tail_q;
  logic [CntWidth-1:0]    count_q;
  logic [StreakWidth-1:0] streak_q;

  logic space;
  logic streak_max;
  logic grant_pass;
  logic grant_local;
  logic push;
  logic pop;

  // Space depends only on stored occupancy, never on ring_ready_i.
  assign space      = count_q < CntWidth'(FifoDepth);
  assign streak_max = streak_q >= StreakWidth'(MaxPassStreak);

  // Pass-through wins unless local has waited out a full streak.
  always_comb begin
    grant_pass  = 1'b0;
    grant_local = 1'b0;
    if (space) begin
      if (pass_valid_i && (!local_valid_i || !streak_max)) begin
        grant_pass = 1'b1;
      end else if (local_valid_i) begin
        grant_local = 1'b1;
      end
    end
  end

  assign pass_ready_o  = grant_pass & ~rst_i;
  assign local_ready_o = grant_local & ~rst_i;
  assign push          = pass_ready_o | local_ready_o;
  assign pop           = ring_valid_o & ring_ready_i;

  always_ff @(posedge clk_i) begin
    if (push) begin
      mem_q[tail_q] <= '{src: local_ready_o, data: local_ready_o ? local_data_i : pass_data_i};
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      head_q   <= '0;
      tail_q   <= '0;
      count_q  <= '0;
      streak_q <= '0;
    end else begin
      if (push) tail_q <= tail_q + PtrWidth'(1);
      if (pop)  head_q <= head_q + PtrWidth'(1);
      if (push && !pop) begin
        count_q <= count_q + CntWidth'(1);
      end else if (!push && pop) begin
        count_q <= count_q - CntWidth'(1);
      end
      // Streak only measures pass grants made while local is actually waiting.
      if (!local_valid_i || local_ready_o) begin
        streak_q <= '0;
      end else if (pass_ready_o && !streak_max) begin
        streak_q <= streak_q + StreakWidth'(1);
      end
    end
  end

  assign occupancy_o  = count_q;
  assign ring_valid_o = count_q != '0;
  assign ring_data_o  = ring_valid_o ? mem_q[head_q].data : '0;
  assign local_src_o  = ring_valid_o ? mem_q[head_q].src : 1'b0;

  a_no_push_when_full : assert property (@(posedge clk_i) disable iff (rst_i) !(push && !space));

endmodule

// File: tb/tb_ring_link_arbiter.sv
// Scoreboard bench for ring_link_arbiter: directed source queues, hand-ordered
// expected link output, and a monitor that checks every popped beat.
module tb_ring_link_arbiter;

  localparam int unsigned DW = 64;

  logic          clk_i;
  logic          rst_i;
  logic [DW-1:0] pass_data_i;
  logic          pass_valid_i;
  logic          pass_ready_o;
  logic [DW-1:0] local_data_i;
  logic          local_valid_i;
  logic          local_ready_o;
  logic [DW-1:0] ring_data_o;
  logic          ring_valid_o;
  logic          ring_ready_i;
  logic [1:0]    occupancy_o;
  logic          local_src_o;

  ring_link_arbiter #(.DataWidth(DW), .FifoDepth(2), .MaxPassStreak(4)) dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .pass_data_i   (pass_data_i),
    .pass_valid_i  (pass_valid_i),
    .pass_ready_o  (pass_ready_o),
    .local_data_i  (local_data_i),
    .local_valid_i (local_valid_i),
    .local_ready_o (local_ready_o),
    .ring_data_o   (ring_data_o),
    .ring_valid_o  (ring_valid_o),
    .ring_ready_i  (ring_ready_i),
    .occupancy_o   (occupancy_o),
    .local_src_o   (local_src_o)
  );

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] pass_q [$];
  logic [DW-1:0] local_q [$];
  logic [DW:0]   exp_q [$];
  logic          local_en;
  logic          p_hs;
  logic          l_hs;
  logic [DW:0]   exp_e;

  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  // Requester obligation: a stalled pass-through beat must stay valid and stable.
  a_pass_stable : assert property (@(posedge clk_i) disable iff (rst_i)
    (pass_valid_i && !pass_ready_o) |=> (pass_valid_i && $stable(pass_data_i)))
    else begin
      errors++;
      $display("FAIL pass_valid_stability actual=changed required=held");
    end

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #3;
  endtask

  task automatic exp_push(input logic src, input logic [DW-1:0] d);
    exp_q.push_back({src, d});
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || ring_valid_o) && n < 200) begin
      tick();
      n++;
    end
    check({name, "_drain_timeout"}, DW'(n < 200), DW'(1));
    check({name, "_occ_empty"}, DW'(occupancy_o), DW'(0));
  endtask

  initial begin
    rst_i         = 1'b1;
    ring_ready_i  = 1'b1;
    pass_valid_i  = 1'b0;
    pass_data_i   = '0;
    local_valid_i = 1'b0;
    local_data_i  = '0;
    local_en      = 1'b1;
    p_hs          = 1'b0;
    l_hs          = 1'b0;

    fork
      // Source driver: holds each beat until its handshake is seen.
      forever begin
        @(negedge clk_i);
        p_hs = pass_valid_i && pass_ready_o;
        l_hs = local_valid_i && local_ready_o;
        @(posedge clk_i);
        #1;
        if (p_hs && pass_q.size() != 0) void'(pass_q.pop_front());
        if (l_hs && local_q.size() != 0) void'(local_q.pop_front());
        pass_valid_i  = pass_q.size() != 0;
        pass_data_i   = (pass_q.size() != 0) ? pass_q[0] : '0;
        local_valid_i = local_en && (local_q.size() != 0);
        local_data_i  = (local_q.size() != 0) ? local_q[0] : '0;
      end
      // Monitor: every link handshake must match the scoreboard head.
      forever begin
        @(negedge clk_i);
        if (!rst_i && ring_valid_o && ring_ready_i) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_beat actual=%0h required=none", ring_data_o);
          end else begin
            exp_e = exp_q.pop_front();
            check("ring_data", ring_data_o, exp_e[DW-1:0]);
            check("local_src", DW'(local_src_o), DW'(exp_e[DW]));
          end
        end
      end
    join_none

    // Reset state, then pass-only stream 0x10..0x17.
    for (int i = 0; i < 8; i++) begin
      pass_q.push_back(DW'(16 + i));
      exp_push(1'b0, DW'(16 + i));
    end
    tick();
    tick();
    @(negedge clk_i);
    check("rst_ring_valid", DW'(ring_valid_o), DW'(0));
    check("rst_occupancy", DW'(occupancy_o), DW'(0));
    check("rst_ring_data", ring_data_o, DW'(0));
    check("rst_local_src", DW'(local_src_o), DW'(0));
    check("rst_pass_ready", DW'(pass_ready_o), DW'(0));
    tick();
    rst_i = 1'b0;
    @(negedge clk_i);
    check("t1_first_not_visible", DW'(ring_valid_o), DW'(0));
    check("t1_pass_ready", DW'(pass_ready_o), DW'(1));
    @(negedge clk_i);
    check("t1_occupancy_one", DW'(occupancy_o), DW'(1));
    drain("t1");

    // Both valid: P,P,P,P,L repeating.
    tick();
    for (int i = 0; i < 12; i++) pass_q.push_back(DW'(8'h20 + i));
    for (int i = 0; i < 3; i++) local_q.push_back(DW'(8'h30 + i));
    for (int i = 0; i < 4; i++) exp_push(1'b0, DW'(8'h20 + i));
    exp_push(1'b1, DW'(8'h30));
    for (int i = 4; i < 8; i++) exp_push(1'b0, DW'(8'h20 + i));
    exp_push(1'b1, DW'(8'h31));
    for (int i = 8; i < 12; i++) exp_push(1'b0, DW'(8'h20 + i));
    exp_push(1'b1, DW'(8'h32));
    drain("t2");

    // Backpressure: two accepts then stall; full pop does not accept same cycle.
    tick();
    ring_ready_i = 1'b0;
    pass_q.push_back(DW'(8'h40));
    pass_q.push_back(DW'(8'h41));
    pass_q.push_back(DW'(8'h42));
    local_q.push_back(DW'(8'h50));
    exp_push(1'b0, DW'(8'h40));
    exp_push(1'b0, DW'(8'h41));
    exp_push(1'b0, DW'(8'h42));
    exp_push(1'b1, DW'(8'h50));
    tick();
    tick();
    tick();
    tick();
    @(negedge clk_i);
    check("t3_full_pass_ready", DW'(pass_ready_o), DW'(0));
    check("t3_full_local_ready", DW'(local_ready_o), DW'(0));
    check("t3_full_occupancy", DW'(occupancy_o), DW'(2));
    tick();
    ring_ready_i = 1'b1;
    @(negedge clk_i);
    check("t3_pop_no_accept", DW'(pass_ready_o), DW'(0));
    tick();
    ring_ready_i = 1'b0;
    @(negedge clk_i);
    check("t3_accept_after_pop", DW'(pass_ready_o), DW'(1));
    check("t3_occupancy_after_pop", DW'(occupancy_o), DW'(1));
    tick();
    ring_ready_i = 1'b1;
    drain("t3");

    // Local-only burst granted back-to-back.
    tick();
    for (int i = 0; i < 4; i++) begin
      local_q.push_back(DW'(8'hA0 + i));
      exp_push(1'b1, DW'(8'hA0 + i));
    end
    @(posedge clk_i);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk_i);
      check("t4_local_ready", DW'(local_ready_o), DW'(1));
    end
    drain("t4");

    // Local drops for one cycle mid-streak: streak clears, local waits 4 more passes.
    tick();
    for (int i = 0; i < 12; i++) pass_q.push_back(DW'(8'h60 + i));
    local_q.push_back(DW'(8'h70));
    for (int i = 0; i < 7; i++) exp_push(1'b0, DW'(8'h60 + i));
    exp_push(1'b1, DW'(8'h70));
    for (int i = 7; i < 12; i++) exp_push(1'b0, DW'(8'h60 + i));
    tick();
    tick();
    local_en = 1'b0;
    tick();
    local_en = 1'b1;
    drain("t5");

    // Asynchronous reset with two entries held; stale data must never appear.
    tick();
    ring_ready_i = 1'b0;
    pass_q.push_back(DW'(8'h80));
    pass_q.push_back(DW'(8'h81));
    pass_q.push_back(DW'(8'h82));
    tick();
    tick();
    tick();
    @(negedge clk_i);
    check("t6_occ_before_rst", DW'(occupancy_o), DW'(2));
    tick();
    rst_i = 1'b1;
    #1;
    check("t6_async_ring_valid", DW'(ring_valid_o), DW'(0));
    check("t6_async_occupancy", DW'(occupancy_o), DW'(0));
    check("t6_async_ring_data", ring_data_o, DW'(0));
    check("t6_async_pass_ready", DW'(pass_ready_o), DW'(0));
    pass_q.delete();
    exp_q.delete();
    tick();
    tick();
    rst_i = 1'b0;
    ring_ready_i = 1'b1;
    pass_q.push_back(DW'(8'h90));
    exp_push(1'b0, DW'(8'h90));
    tick();
    @(negedge clk_i);
    check("t6_accept_cycle_not_visible", DW'(ring_valid_o), DW'(0));
    @(negedge clk_i);
    check("t6_visible_next_cycle", DW'(ring_valid_o), DW'(1));
    drain("t6");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
